// File: rtl/dma_reg_pkg.sv
// Command-register bit positions and arbiter state encoding shared by the DMA priority logic.
// Pure definitions: no latency, no flow control.
package dma_reg_pkg;

  localparam int CMD_DIS        = 2;
  localparam int CMD_ROT        = 4;
  localparam int CMD_DREQ_SENSE = 6;
  localparam int CMD_DACK_SENSE = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HREQ = 2'd1,
    SVC  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dma_prio_encoder.sv
// Fixed/rotating priority encoder: picks the first requesting channel starting at last+1 (rotate) or ch0.
// Purely combinational, zero latency; no flow control.
module dma_prio_encoder #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] eff,
  input  logic [CH_W-1:0]   last,
  input  logic              rotate,
  output logic [CH_W-1:0]   win,
  output logic              vld
);

  function automatic logic [CH_W-1:0] order_idx(input logic [CH_W-1:0] l, input logic rot, input int i);
    return rot ? CH_W'((int'(l) + 1 + i) % NUM_CH) : CH_W'(i);
  endfunction

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    win = '0;
    vld = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eff[order_idx(last, rotate, i)]) begin
        win = order_idx(last, rotate, i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// 8237A-style DMA priority arbiter with HRQ/HLDA hold handshake and non-preemptive service.
// HLDA-high to DACK is 1 cycle; a service holds until SVC_DONE or HLDA drop, then one IDLE cycle.
module dma_priority_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] REQ_REG,
  input  logic [NUM_CH-1:0] MASK_REG,
  input  logic [7:0]        CMD_REG,
  input  logic              HLDA,
  input  logic              SVC_DONE,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic [CH_W-1:0]   ACT_CH,
  output logic              ACT_VLD
);

  import dma_reg_pkg::*;

  arb_state_t        state_q, state_d;
  logic [NUM_CH-1:0] eff;
  logic [NUM_CH-1:0] grant_q;
  logic [CH_W-1:0]   act_ch_q;
  logic [CH_W-1:0]   last_q;
  logic [CH_W-1:0]   win;
  logic              win_vld;
  logic              rotate;

  assign rotate = CMD_REG[CMD_ROT];

  always_comb begin
    eff = ((DREQ ^ {NUM_CH{CMD_REG[CMD_DREQ_SENSE]}}) | REQ_REG) & ~MASK_REG;
    if (CMD_REG[CMD_DIS]) eff = '0;
  end

  dma_prio_encoder #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_enc (
    .eff    (eff),
    .last   (last_q),
    .rotate (rotate),
    .win    (win),
    .vld    (win_vld)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Requests and masks are only looked at outside SVC; a running service cannot be preempted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = HREQ;
      HREQ:    if (!win_vld) state_d = IDLE;
               else if (HLDA) state_d = SVC;
      SVC:     if (SVC_DONE || !HLDA) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      grant_q  <= '0;
      act_ch_q <= '0;
      last_q   <= CH_W'(NUM_CH - 1);
    end else begin
      if (state_q == HREQ && state_d == SVC) begin
        grant_q  <= NUM_CH'(1) << win;
        act_ch_q <= win;
      end else if (state_q == SVC && state_d == IDLE) begin
        grant_q <= '0;
      end
      // Only a completed service advances the pointer; an HLDA abort leaves it alone.
      if (!rotate)                         last_q <= CH_W'(NUM_CH - 1);
      else if (state_q == SVC && SVC_DONE) last_q <= act_ch_q;
    end
  end

  always_comb begin
    HRQ     = (state_q != IDLE);
    ACT_VLD = (state_q == SVC);
    ACT_CH  = act_ch_q;
    DACK    = grant_q ^ {NUM_CH{~CMD_REG[CMD_DACK_SENSE]}};
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter with a cycle-level behavioural model checked every cycle.
module tb_dma_priority_arbiter;

  localparam int NUM_CH = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ, REQ_REG, MASK_REG;
  logic [7:0] CMD_REG;
  logic       HLDA, SVC_DONE;
  logic       HRQ, ACT_VLD;
  logic [3:0] DACK;
  logic [1:0] ACT_CH;

  int checks   = 0;
  int failures = 0;

  dma_priority_arbiter #(.NUM_CH(NUM_CH), .CH_W(2)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .DREQ     (DREQ),
    .REQ_REG  (REQ_REG),
    .MASK_REG (MASK_REG),
    .CMD_REG  (CMD_REG),
    .HLDA     (HLDA),
    .SVC_DONE (SVC_DONE),
    .HRQ      (HRQ),
    .DACK     (DACK),
    .ACT_CH   (ACT_CH),
    .ACT_VLD  (ACT_VLD)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_hrq, m_svc;
  int m_ch, m_last;

  function automatic int pick(input logic [3:0] e, input int l, input bit rot);
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = rot ? (l + 1 + k) % NUM_CH : k;
      if (e[c]) return c;
    end
    return 0;
  endfunction

  initial begin
    logic [3:0] e;
    logic [3:0] exp_dack;
    bit rot;
    forever begin
      @(posedge CLK);
      #1;
      rot = CMD_REG[4];
      if (RESET) begin
        m_hrq = 0; m_svc = 0; m_ch = 0; m_last = NUM_CH - 1;
      end else begin
        e = ((DREQ ^ {4{CMD_REG[6]}}) | REQ_REG) & ~MASK_REG;
        if (CMD_REG[2]) e = 4'b0;
        if (m_svc) begin
          if (SVC_DONE) begin
            m_svc = 0; m_hrq = 0;
            if (rot) m_last = m_ch;
          end else if (!HLDA) begin
            m_svc = 0; m_hrq = 0;
          end
        end else if (m_hrq) begin
          if (e == 4'b0) m_hrq = 0;
          else if (HLDA) begin
            m_svc = 1; m_ch = pick(e, m_last, rot);
          end
        end else if (e != 4'b0) begin
          m_hrq = 1;
        end
        if (!rot) m_last = NUM_CH - 1;
      end
      exp_dack = (m_svc ? (4'b0001 << m_ch) : 4'b0000) ^ {4{~CMD_REG[7]}};
      chk("model_hrq", 32'(HRQ), 32'(m_hrq));
      chk("model_act_vld", 32'(ACT_VLD), 32'(m_svc));
      chk("model_act_ch", 32'(ACT_CH), 32'(m_ch));
      chk("model_dack", 32'(DACK), 32'(exp_dack));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic wait_vld(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (ACT_VLD === 1'b1) seen = 1;
    end
    if (!seen) begin
      failures++;
      $display("FAIL %s timeout actual=ACT_VLD_low required=ACT_VLD_high", name);
    end
  endtask

  task automatic finish_svc(input logic [3:0] next_dreq);
    SVC_DONE = 1'b1;
    DREQ     = next_dreq;
    tick();
    SVC_DONE = 1'b0;
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    RESET = 1'b1; DREQ = '0; REQ_REG = '0; MASK_REG = '0; CMD_REG = 8'h00;
    HLDA = 1'b0; SVC_DONE = 1'b0;
    #1;
    chk("rst_hrq", 32'(HRQ), 0);
    chk("rst_dack", 32'(DACK), 32'hF);
    chk("rst_act_vld", 32'(ACT_VLD), 0);
    chk("rst_act_ch", 32'(ACT_CH), 0);
    tick(); tick();
    RESET = 1'b0;
    tick();

    // 1: fixed priority, ch1 beats ch3
    DREQ = 4'b1010;
    #1 chk("t1_hrq_before_edge", 32'(HRQ), 0);
    tick();
    chk("t1_hrq", 32'(HRQ), 1);
    chk("t1_vld_before_hlda", 32'(ACT_VLD), 0);
    HLDA = 1'b1;
    tick();
    chk("t1_dack", 32'(DACK), 32'hD);
    chk("t1_act_ch", 32'(ACT_CH), 1);
    chk("t1_act_vld", 32'(ACT_VLD), 1);
    finish_svc(4'b0000);
    chk("t1_done_hrq", 32'(HRQ), 0);
    chk("t1_done_dack", 32'(DACK), 32'hF);
    HLDA = 1'b0;
    tick();

    // 2: rotating priority round robin
    CMD_REG = 8'h10; DREQ = 4'b1111; HLDA = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_vld("t2_wait");
      chk("t2_order", 32'(ACT_CH), 32'(exp_order[k]));
      finish_svc(k == 4 ? 4'b0000 : 4'b1111);
    end
    CMD_REG = 8'h00; HLDA = 1'b0;
    tick();

    // 3: mask blocks hardware request, software request gets through
    MASK_REG = 4'b0001; DREQ = 4'b0001;
    tick(); tick(); tick();
    chk("t3_masked_hrq", 32'(HRQ), 0);
    REQ_REG = 4'b0100;
    tick();
    chk("t3_sw_hrq", 32'(HRQ), 1);
    HLDA = 1'b1;
    tick();
    chk("t3_act_ch", 32'(ACT_CH), 2);
    chk("t3_dack", 32'(DACK), 32'hB);
    REQ_REG = 4'b0000;
    finish_svc(4'b0000);
    MASK_REG = 4'b0000; HLDA = 1'b0;
    tick();

    // 4: active-low DREQ, active-high DACK
    CMD_REG = 8'hC0; DREQ = 4'b1110; HLDA = 1'b1;
    wait_vld("t4_wait");
    chk("t4_act_ch", 32'(ACT_CH), 0);
    chk("t4_dack", 32'(DACK), 32'h1);
    finish_svc(4'b1111);
    chk("t4_idle_dack", 32'(DACK), 32'h0);
    CMD_REG = 8'h00; DREQ = 4'b0000; HLDA = 1'b0;
    tick();

    // 5a: disable in IDLE blocks, disable in SVC is ignored
    CMD_REG = 8'h04; DREQ = 4'b1111;
    tick(); tick(); tick();
    chk("t5_dis_hrq", 32'(HRQ), 0);
    CMD_REG = 8'h00;
    tick();
    chk("t5_hrq", 32'(HRQ), 1);
    HLDA = 1'b1;
    tick();
    chk("t5_act_ch", 32'(ACT_CH), 0);
    CMD_REG = 8'h04; DREQ = 4'b0000;
    tick();
    chk("t5_dis_svc_vld", 32'(ACT_VLD), 1);
    chk("t5_dis_svc_dack", 32'(DACK), 32'hE);
    finish_svc(4'b0000);
    chk("t5_done_vld", 32'(ACT_VLD), 0);
    CMD_REG = 8'h00;

    // 5b: HLDA abort leaves rotation pointer at 3, so ch0 beats ch3
    CMD_REG = 8'h10; DREQ = 4'b0100; HLDA = 1'b1;
    wait_vld("t5_abort_wait");
    chk("t5_abort_ch", 32'(ACT_CH), 2);
    HLDA = 1'b0;
    tick();
    chk("t5_abort_vld", 32'(ACT_VLD), 0);
    chk("t5_abort_hrq", 32'(HRQ), 0);
    DREQ = 4'b1001; HLDA = 1'b1;
    wait_vld("t5_after_abort_wait");
    chk("t5_after_abort_ch", 32'(ACT_CH), 0);
    finish_svc(4'b0000);

    // 6: reset mid-service restores pointer (ch3 would otherwise win)
    DREQ = 4'b0010;
    wait_vld("t6_ch1_wait");
    chk("t6_ch1", 32'(ACT_CH), 1);
    finish_svc(4'b1000);
    wait_vld("t6_ch3_wait");
    chk("t6_ch3", 32'(ACT_CH), 3);
    #3 RESET = 1'b1;
    #1;
    chk("t6_rst_hrq", 32'(HRQ), 0);
    chk("t6_rst_dack", 32'(DACK), 32'hF);
    chk("t6_rst_vld", 32'(ACT_VLD), 0);
    tick();
    RESET = 1'b0; DREQ = 4'b1001;
    wait_vld("t6_after_rst_wait");
    chk("t6_after_rst_ch", 32'(ACT_CH), 0);
    finish_svc(4'b0000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
